coin_credit_accumulator: RTL and testbench
==========================================

// Module: coin_credit_accumulator
// PURPOSE
// Front-end stage feeding smart_vending_machine. Sums coins into a credit register and offers the total on
// money_inserted once the customer confirms. Holds the offer until the vending stage acknowledges it.
// Returns the full credit as a refund on cancel or inactivity timeout.
// PARAMETERS
// W               8     width of credit/money paths (matches money_inserted [7:0])
// MAX_CREDIT      200   max accepted credit; coin that would exceed it is rejected
// TIMEOUT_CYCLES  1000  consecutive idle COLLECT cycles before auto-refund (>=2)
// PORTS
// clk            in   1    rising-edge clock
// reset          in   1    asynchronous, active-low reset (0 = reset)
// coin_valid     in   1    one-cycle coin-inserted strobe
// coin_code      in   2    00=5, 01=10, 10=20, 11=50 (rupees)
// confirm        in   1    customer request to offer credit downstream
// cancel         in   1    customer request to refund
// vend_ack       in   1    downstream consumed money_inserted (one-cycle pulse)
// money_inserted out  W    offered credit; 0 unless credit_valid
// credit_valid   out  1    money_inserted is valid; held until vend_ack
// credit         out  W    current accumulated credit (display)
// coin_reject    out  1    one-cycle pulse: coin on this cycle was not accepted
// refund_valid   out  1    one-cycle pulse: refund_amount valid
// refund_amount  out  W    refunded value; 0 unless refund_valid
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE; credit, money_inserted, refund_amount, timer = 0; all flags 0.
//   Reset mid-operation discards credit with no refund pulse.
// - All outputs registered; every effect is visible the cycle after the causing input edge.
// - FSM states: IDLE, COLLECT, OFFER, REFUND.
// - IDLE: accepted coin -> credit=value, go COLLECT. confirm/cancel/vend_ack ignored.
// - COLLECT, priority cancel > confirm > coin:
//   cancel -> REFUND. confirm with credit>0 -> OFFER.
//   A coin in the same cycle as cancel/confirm is rejected.
//   Otherwise a coin is accepted if credit+value <= MAX_CREDIT. Else coin_reject=1 and credit is unchanged.
// - Sum computed in W+1 bits; credit never wraps.
// - Timer: cleared on entering COLLECT and on each accepted coin.
//   Incremented on each COLLECT cycle with no coin/confirm/cancel.
//   When the timer reaches TIMEOUT_CYCLES-1 on such a cycle, go REFUND.
// - OFFER: credit_valid=1, money_inserted=credit, both stable until vend_ack.
//   vend_ack -> IDLE with credit=0; vend_ack wins over a same-cycle cancel.
//   cancel without vend_ack -> REFUND. All coins in OFFER are rejected.
// - REFUND: refund_valid=1 and refund_amount=credit for exactly one cycle. Then IDLE with credit=0.
//   Coins in REFUND are rejected.
// - vend_ack outside OFFER is ignored. confirm with credit=0 is ignored.
// TESTING
// 1 coins 20,5 then confirm -> credit=25, credit_valid=1, money_inserted=25 held; vend_ack -> all 0 next cycle
// 2 coins 50x4 (credit=200), then coin 5 -> coin_reject pulse, credit stays 200; confirm -> money_inserted=200
// 3 coins 20,10 then cancel -> refund_valid 1 cycle, refund_amount=30, then credit=0 in IDLE
// 4 TIMEOUT_CYCLES=16: coin 10 then 16 idle cycles -> refund_valid with 10 on the cycle after the 16th
// 5 coin+confirm same cycle -> reject, OFFER; in OFFER coin -> reject; cancel+vend_ack -> IDLE, no refund
// 6 reset=0 asynchronously during OFFER -> credit_valid/money_inserted/credit drop to 0 before next clk edge

Source files
------------

// File: rtl/coin_credit_accumulator_if.sv
// Coin/credit bundle between the customer front end and the vending stage.
// The master side drives coins and requests; the slave side returns credit.
interface coin_credit_accumulator_if #(
  parameter int W = 8
);
  logic         coin_valid;
  logic [1:0]   coin_code;
  logic         confirm;
  logic         cancel;
  logic         vend_ack;
  logic [W-1:0] money_inserted;
  logic         credit_valid;
  logic [W-1:0] credit;
  logic         coin_reject;
  logic         refund_valid;
  logic [W-1:0] refund_amount;

  modport master (
    output coin_valid, coin_code,
    output confirm, cancel, vend_ack,
    input  money_inserted, credit_valid,
    input  credit, coin_reject,
    input  refund_valid, refund_amount
  );

  modport slave (
    input  coin_valid, coin_code,
    input  confirm, cancel, vend_ack,
    output money_inserted, credit_valid,
    output credit, coin_reject,
    output refund_valid, refund_amount
  );
endinterface

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: sums coins, offers credit downstream,
// refunds on cancel or inactivity timeout.
module coin_credit_accumulator #(
  parameter int W              = 8,
  parameter int MAX_CREDIT     = 200,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  coin_credit_accumulator_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE, COLLECT, OFFER, REFUND
  } state_t;

  state_t       r_state, w_next;
  logic [W-1:0] r_credit, w_credit;
  logic [TW-1:0] r_timer, w_timer;
  logic         r_credit_valid;
  logic [W-1:0] r_money;
  logic         r_reject, w_reject;
  logic         r_refund_valid;
  logic [W-1:0] r_refund_amt;
  logic         w_accept;
  logic [W-1:0] w_val;
  logic [W:0]   w_sum;
  logic         w_fits, w_quiet, w_tmo;

  always_comb begin
    unique case (bus.coin_code)
      2'b00: w_val = W'(5);
      2'b01: w_val = W'(10);
      2'b10: w_val = W'(20);
      2'b11: w_val = W'(50);
    endcase
  end

  // Sum is one bit wider so an over-limit coin can't wrap.
  assign w_sum   = {1'b0, r_credit} + {1'b0, w_val};
  assign w_fits  = w_sum <= (W+1)'(MAX_CREDIT);
  assign w_quiet = !bus.coin_valid && !bus.confirm
                && !bus.cancel;
  assign w_tmo   = r_timer == TW'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_timer        <= '0;
      r_credit_valid <= 1'b0;
      r_money        <= '0;
      r_reject       <= 1'b0;
      r_refund_valid <= 1'b0;
      r_refund_amt   <= '0;
    end else begin
      r_state        <= w_next;
      r_credit       <= w_credit;
      r_timer        <= w_timer;
      r_credit_valid <= w_next == OFFER;
      r_money        <= (w_next == OFFER) ? w_credit : '0;
      r_reject       <= w_reject;
      r_refund_valid <= w_next == REFUND;
      r_refund_amt   <= (w_next == REFUND) ? w_credit : '0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.coin_valid && w_fits) w_next = COLLECT;
      end
      COLLECT: begin
        if (bus.cancel)
          w_next = REFUND;
        else if (bus.confirm && r_credit != '0)
          w_next = OFFER;
        else if (w_quiet && w_tmo)
          w_next = REFUND;
      end
      OFFER: begin
        if (bus.vend_ack)    w_next = IDLE;
        else if (bus.cancel) w_next = REFUND;
      end
      REFUND: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_credit = r_credit;
    w_timer  = r_timer;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.coin_valid && w_fits) begin
          w_accept = 1'b1;
          w_credit = w_sum[W-1:0];
          w_timer  = '0;
        end
      end
      COLLECT: begin
        if (!bus.cancel && !bus.confirm
            && bus.coin_valid && w_fits) begin
          w_accept = 1'b1;
          w_credit = w_sum[W-1:0];
          w_timer  = '0;
        end else if (w_quiet && !w_tmo) begin
          w_timer = r_timer + TW'(1);
        end
      end
      OFFER: begin
        if (bus.vend_ack) w_credit = '0;
      end
      REFUND: w_credit = '0;
    endcase
    w_reject = bus.coin_valid && !w_accept;
  end

  assign bus.money_inserted = r_money;
  assign bus.credit_valid   = r_credit_valid;
  assign bus.credit         = r_credit;
  assign bus.coin_reject    = r_reject;
  assign bus.refund_valid   = r_refund_valid;
  assign bus.refund_amount  = r_refund_amt;
endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Scoreboard bench for coin_credit_accumulator with a
// behavioural credit model and randomized coin traffic.
module tb_coin_credit_accumulator;
  localparam int W   = 8;
  localparam int MAX = 200;
  localparam int TO  = 16;

  typedef struct packed {
    logic         cv;
    logic [W-1:0] mi;
    logic [W-1:0] cr;
    logic         rej;
    logic         rv;
    logic [W-1:0] ra;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  coin_credit_accumulator_if #(.W(W)) bus ();

  coin_credit_accumulator #(
    .W(W), .MAX_CREDIT(MAX), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  out_t sb[$];

  // Model: phase 0 idle, 1 collecting, 2 offering, 3 refunding
  int m_phase = 0;
  int m_credit = 0;
  int m_quiet = 0;
  int vals[4] = '{5, 10, 20, 50};

  function automatic out_t sample();
    out_t a;
    a.cv  = bus.credit_valid;
    a.mi  = bus.money_inserted;
    a.cr  = bus.credit;
    a.rej = bus.coin_reject;
    a.rv  = bus.refund_valid;
    a.ra  = bus.refund_amount;
    return a;
  endfunction

  task automatic compare(input string nm,
                         input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got cv=%0d mi=%0d cr=%0d rej=%0d rv=%0d ra=%0d want cv=%0d mi=%0d cr=%0d rej=%0d rv=%0d ra=%0d",
        nm, $time, a.cv, a.mi, a.cr, a.rej, a.rv, a.ra,
        e.cv, e.mi, e.cr, e.rej, e.rv, e.ra);
    end
  endtask

  function automatic out_t model_step(bit cv, int code,
                                      bit cf, bit cn, bit ack);
    out_t e;
    int v;
    int refund;
    v = vals[code];
    refund = -1;
    e = '0;
    case (m_phase)
      0: if (cv) begin
        m_credit = v; m_phase = 1; m_quiet = 0;
      end
      1: begin
        if (cn) begin
          e.rej = cv; refund = m_credit; m_phase = 3;
        end else if (cf) begin
          e.rej = cv;
          if (m_credit > 0) m_phase = 2;
        end else if (cv) begin
          if (m_credit + v <= MAX) begin
            m_credit += v; m_quiet = 0;
          end else e.rej = 1'b1;
        end else begin
          m_quiet++;
          if (m_quiet == TO) begin
            refund = m_credit; m_phase = 3;
          end
        end
      end
      2: begin
        e.rej = cv;
        if (ack) begin
          m_credit = 0; m_phase = 0;
        end else if (cn) begin
          refund = m_credit; m_phase = 3;
        end
      end
      default: begin
        e.rej = cv; m_credit = 0; m_phase = 0;
      end
    endcase
    e.cv = (m_phase == 2);
    e.mi = (m_phase == 2) ? W'(m_credit) : '0;
    e.cr = W'(m_credit);
    e.rv = (refund >= 0);
    e.ra = (refund >= 0) ? W'(refund) : '0;
    return e;
  endfunction

  task automatic cyc(input bit cv, input int code,
                     input bit cf, input bit cn,
                     input bit ack);
    @(negedge clk);
    bus.coin_valid = cv;
    bus.coin_code  = 2'(code);
    bus.confirm    = cf;
    bus.cancel     = cn;
    bus.vend_ack   = ack;
    sb.push_back(model_step(cv, code, cf, cn, ack));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int code);
    cyc(1, code, 0, 0, 0);
  endtask

  out_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      compare("scoreboard", sample(), mon_e);
    end
  end

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_code  = 2'b00;
    bus.confirm    = 1'b0;
    bus.cancel     = 1'b0;
    bus.vend_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1 compare("reset_state", sample(), '0);
    @(negedge clk) reset = 1'b1;

    coin(2); coin(0); cyc(0, 0, 1, 0, 0);
    idle(4); cyc(0, 0, 0, 0, 1); idle(2);

    repeat (4) coin(3);
    coin(0); cyc(0, 0, 1, 0, 0);
    idle(2); cyc(0, 0, 0, 0, 1); idle(1);

    coin(2); coin(1); cyc(0, 0, 0, 1, 0); idle(3);

    coin(1); idle(TO + 3);

    coin(0); cyc(1, 1, 1, 0, 0); coin(2);
    cyc(0, 0, 0, 1, 1); idle(2);

    coin(2); cyc(0, 0, 1, 0, 0); idle(1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 compare("async_reset", sample(), '0);
    m_phase = 0; m_credit = 0; m_quiet = 0;
    @(negedge clk) reset = 1'b1;

    for (int s = 0; s < 60; s++) begin
      int dens;
      int len;
      dens = $urandom_range(0, 3);
      len  = $urandom_range(5, 40);
      for (int i = 0; i < len; i++) begin
        cyc($urandom_range(0, 9) < dens * 3,
            $urandom_range(0, 3),
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 5) == 0);
      end
    end
    idle(2);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
